// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_buffer
//  Description : Captures {pc, Rd_in} for each retired instruction into a FIFO.
//                Drains the FIFO as 9-byte big-endian frames (header, pc,
//                Rd_in) over a valid/ready byte stream. Lost captures set a
//                sticky flag and increment a saturating drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
    parameter int          DEPTH  = 16,
    parameter int          ADDR_W = 4,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trace_en,
    input  logic [31:0]       pc,
    input  logic [31:0]       Rd_in,
    input  logic              ovf_clr,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W:0]   level,
    output logic              ovf_flag,
    output logic [15:0]       drop_count
);

    localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      c_LAST_IDX = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Storage and pointers
    logic [63:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;

    // Overflow bookkeeping
    logic              r_ovf;
    logic [15:0]       r_drop;

    // Frame transmitter
    state_t            r_state;
    logic [71:0]       r_frame;
    logic [3:0]        r_idx;
    logic              r_tx_valid;

    // Handshake / push / pop decisions, all from pre-edge state
    logic              w_nonempty;
    logic              w_full;
    logic              w_hs;
    logic              w_last;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [63:0]       w_head;

    assign w_nonempty = (r_level != '0);
    assign w_full     = (r_level == c_DEPTH);
    assign w_hs       = r_tx_valid && tx_ready;
    assign w_last     = (r_idx == c_LAST_IDX);
    // A pop happens when idle with data, or when the final byte of a frame
    // is accepted and another entry is waiting (back-to-back frames).
    assign w_pop      = w_nonempty &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_SEND) && w_hs && w_last));
    // A full FIFO still accepts a capture if a slot frees up this same edge.
    assign w_push     = trace_en && (!w_full || w_pop);
    assign w_drop     = trace_en && !w_push;
    assign w_head     = r_mem[r_rd_ptr];

    // FIFO storage write; contents need no reset since pointers gate them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pc, Rd_in};
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf  <= 1'b1;
            if (ovf_clr) begin
                r_drop <= 16'd1;
            end else if (r_drop != 16'hFFFF) begin
                r_drop <= r_drop + 16'd1;
            end
        end else if (ovf_clr) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end
    end

    // Frame sender: the frame register shifts left so the current byte is
    // always its top octet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_frame    <= '0;
            r_idx      <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_frame    <= {HEADER, w_head};
                        r_idx      <= '0;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEND;
                    end else begin
                        r_tx_valid <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        if (!w_last) begin
                            r_frame <= {r_frame[63:0], 8'h00};
                            r_idx   <= r_idx + 4'd1;
                        end else if (w_pop) begin
                            r_frame <= {HEADER, w_head};
                            r_idx   <= '0;
                        end else begin
                            r_frame    <= '0;
                            r_idx      <= '0;
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data    = r_frame[71:64];
    assign tx_valid   = r_tx_valid;
    assign level      = r_level;
    assign ovf_flag   = r_ovf;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Downstream observer of mono_cpu.
- The CPU retires one instruction per clk. Each cycle, this block captures the retired pc and the Rd_in write-back value into a FIFO.
- It drains the FIFO as 9-byte frames over a valid/ready byte stream toward the board's debug UART transmitter.
- Losses on overflow are reported through a sticky flag and a saturating drop counter, so the host can detect gaps in the trace.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, same clock as mono_cpu.
- rst_n  input  1  asynchronous active-low reset.
- trace_en  input  1  capture enable.
- pc  input  32  retired instruction address from mono_cpu.
- Rd_in  input  32  write-back value from mono_cpu.
- ovf_clr  input  1  clears ovf_flag and drop_count.
- tx_data  output  8  current frame byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte.
- level  output  ADDR_W+1  FIFO occupancy, 0..DEPTH.
- ovf_flag  output  1  sticky: at least one capture was dropped.
- drop_count  output  16  saturating count of dropped captures.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - FIFO pointers 0, level=0.
  - tx_valid=0, tx_data=0.
  - ovf_flag=0, drop_count=0.
  - FSM in IDLE, byte index 0.
- Capture (push):
  - Every rising clk with trace_en=1, request a push of {pc, Rd_in}.
  - The push is accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the capture is dropped: ovf_flag<=1 and drop_count<=drop_count+1, saturating at 16'hFFFF.
- ovf_clr:
  - ovf_clr=1 clears ovf_flag and drop_count next cycle.
  - If a drop happens in the same cycle as ovf_clr, the drop wins: ovf_flag=1, drop_count=1.
- level:
  - Registered.
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Pointers wrap modulo DEPTH.
- Frame format, 9 bytes, big-endian:
  - Byte 0: HEADER.
  - Bytes 1-4: pc[31:24], pc[23:16], pc[15:8], pc[7:0].
  - Bytes 5-8: Rd_in[31:24] down to Rd_in[7:0].
- FSM states: IDLE, SEND.
- IDLE:
  - If level>0, pop the head entry into a 72-bit frame register, set byte index=0, assert tx_valid next cycle, go to SEND.
  - Otherwise tx_valid=0.
- SEND:
  - tx_valid=1 and tx_data=frame byte[index].
  - While tx_ready=0, tx_data and tx_valid hold stable.
  - A handshake (tx_valid and tx_ready high on the same edge) on index<8 increments the index.
  - A handshake on index 8:
    - If level>0 (pre-pop value), pop the next entry in that same cycle, set index=0, stay in SEND. This gives back-to-back frames with no bubble.
    - Otherwise tx_valid<=0 and go to IDLE.
- Latency:
  - A capture into an empty FIFO while in IDLE is pushed at edge N.
  - It is popped at edge N+1; tx_valid=1 with HEADER after edge N+1.
  - Minimum frame time is 9 cycles with tx_ready held at 1.
- Push and pop use independent pointers. An entry pushed in the same cycle the FIFO goes empty is not popped until the next cycle; no bypass.
- Reset mid-frame: the frame and FIFO contents are discarded and all outputs return to reset values immediately (asynchronous). No partial frame resumes after reset.
- trace_en=0 stops captures only; draining continues.

Test Plan:
- Reset, trace_en=1 for one cycle with pc=32'h00000004, Rd_in=32'hDEADBEEF, tx_ready=1 -> tx_data sequence A5,00,00,00,04,DE,AD,BE,EF. tx_valid is high for exactly 9 consecutive cycles, then 0. level returns to 0.
- Two back-to-back captures (pc=0x0,0x4), tx_ready=1 -> 18 consecutive valid bytes with no bubble between frames. The second header appears in the cycle right after byte EF of the first frame.
- tx_ready=0 for 5 cycles during byte 3 -> tx_data holds pc[15:8] and tx_valid stays 1. The sequence resumes correctly after tx_ready rises.
- tx_ready=0, trace_en=1 for 20 cycles, DEPTH=16 -> level saturates at 16. ovf_flag=1, drop_count=3 or 4 depending on the in-flight pop; the check is that level + popped + dropped = 20. Then pulse ovf_clr -> ovf_flag=0, drop_count=0.
- At level=16, a push in the cycle a frame-end pop occurs -> push accepted, level stays 16, drop_count unchanged.
- Assert rst_n=0 mid-frame at byte 4 with level=5 -> tx_valid=0, level=0, ovf_flag=0 immediately. After release there is no output until a new capture.
